// File: rtl/status_blink_coder.sv
// Blink-code override source: repeats a 1-7 pulse status code as ON/OFF pulses
// followed by a dark gap, with a single-entry pending slot for the next code.
module status_blink_coder #(
  parameter int TICK_DIV  = 50000,
  parameter int ON_TICKS  = 250,
  parameter int OFF_TICKS = 250,
  parameter int GAP_TICKS = 1000
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       code_valid,
  input  logic [2:0] code,
  output logic       code_ready,
  input  logic       clear,
  output logic       busy,
  output logic       led_override_en,
  output logic [1:0] led_override
);

  localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_TICKS  = (MAX_ON_OFF > GAP_TICKS) ? MAX_ON_OFF : GAP_TICKS;
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int TW = $clog2(MAX_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE_ON  = 2'd1,
    PULSE_OFF = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic [TW-1:0] tick_cnt_r, tick_cnt_nxt_s;
  logic [2:0]    pulse_cnt_r, pulse_cnt_nxt_s;
  logic [2:0]    active_code_r, active_code_nxt_s;
  logic          pend_valid_r, pend_valid_nxt_s;
  logic [2:0]    pend_code_r, pend_code_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          en_r, en_nxt_s;
  logic [1:0]    led_r, led_nxt_s;

  logic tick_s, accept_s, enter_s;
  logic on_done_s, off_done_s, gap_done_s;

  assign tick_s     = (presc_r == PW'(TICK_DIV - 1));
  assign code_ready = !clear && ((state_r == IDLE) || !pend_valid_r);
  assign accept_s   = code_valid && code_ready;
  assign on_done_s  = tick_s && (tick_cnt_r == TW'(ON_TICKS - 1));
  assign off_done_s = tick_s && (tick_cnt_r == TW'(OFF_TICKS - 1));
  assign gap_done_s = tick_s && (tick_cnt_r == TW'(GAP_TICKS - 1));

  assign busy            = busy_r;
  assign led_override_en = en_r;
  assign led_override    = led_r;

  // State register, timing counters, code storage and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r       <= IDLE;
      presc_r       <= '0;
      tick_cnt_r    <= '0;
      pulse_cnt_r   <= 3'd0;
      active_code_r <= 3'd0;
      pend_valid_r  <= 1'b0;
      pend_code_r   <= 3'd0;
      busy_r        <= 1'b0;
      en_r          <= 1'b0;
      led_r         <= 2'b00;
    end else begin
      state_r       <= state_nxt_s;
      presc_r       <= presc_nxt_s;
      tick_cnt_r    <= tick_cnt_nxt_s;
      pulse_cnt_r   <= pulse_cnt_nxt_s;
      active_code_r <= active_code_nxt_s;
      pend_valid_r  <= pend_valid_nxt_s;
      pend_code_r   <= pend_code_nxt_s;
      busy_r        <= busy_nxt_s;
      en_r          <= en_nxt_s;
      led_r         <= led_nxt_s;
    end
  end

  // Next-state, code bookkeeping and counter updates
  always_comb begin
    state_nxt_s       = state_r;
    pulse_cnt_nxt_s   = pulse_cnt_r;
    active_code_nxt_s = active_code_r;
    pend_valid_nxt_s  = pend_valid_r;
    pend_code_nxt_s   = pend_code_r;
    enter_s           = 1'b0;

    if (clear) begin
      state_nxt_s       = IDLE;
      pulse_cnt_nxt_s   = 3'd0;
      active_code_nxt_s = 3'd0;
      pend_valid_nxt_s  = 1'b0;
      pend_code_nxt_s   = 3'd0;
      enter_s           = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && (code != 3'd0)) begin
            state_nxt_s       = PULSE_ON;
            pulse_cnt_nxt_s   = code;
            active_code_nxt_s = code;
            enter_s           = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        PULSE_ON: begin
          if (on_done_s) begin
            enter_s = 1'b1;
            if (pulse_cnt_r == 3'd1) begin
              state_nxt_s = GAP;
            end else begin
              pulse_cnt_nxt_s = pulse_cnt_r - 3'd1;
              state_nxt_s     = PULSE_OFF;
            end
          end else begin
            state_nxt_s = PULSE_ON;
          end
        end
        PULSE_OFF: begin
          if (off_done_s) begin
            state_nxt_s = PULSE_ON;
            enter_s     = 1'b1;
          end else begin
            state_nxt_s = PULSE_OFF;
          end
        end
        GAP: begin
          if (gap_done_s) begin
            enter_s = 1'b1;
            if (pend_valid_r) begin
              pend_valid_nxt_s = 1'b0;
              if (pend_code_r == 3'd0) begin
                state_nxt_s     = IDLE;
                pulse_cnt_nxt_s = 3'd0;
              end else begin
                state_nxt_s       = PULSE_ON;
                active_code_nxt_s = pend_code_r;
                pulse_cnt_nxt_s   = pend_code_r;
              end
            end else begin
              state_nxt_s     = PULSE_ON;
              pulse_cnt_nxt_s = active_code_r;
            end
          end else begin
            state_nxt_s = GAP;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          enter_s     = 1'b1;
        end
      endcase

      // Ready is only high here when the slot is empty, so this never overwrites
      if (accept_s && (state_r != IDLE)) begin
        pend_valid_nxt_s = 1'b1;
        pend_code_nxt_s  = code;
      end else begin
        pend_code_nxt_s = pend_code_nxt_s;
      end
    end

    if (enter_s || (state_r == IDLE) || tick_s) begin
      presc_nxt_s = '0;
    end else begin
      presc_nxt_s = presc_r + PW'(1);
    end

    if (enter_s || (state_r == IDLE)) begin
      tick_cnt_nxt_s = '0;
    end else if (tick_s) begin
      tick_cnt_nxt_s = tick_cnt_r + TW'(1);
    end else begin
      tick_cnt_nxt_s = tick_cnt_r;
    end
  end

  // Outputs decoded from next state so they move on the same edge as the state
  always_comb begin
    busy_nxt_s = (state_nxt_s != IDLE);
    en_nxt_s   = (state_nxt_s != IDLE);
    if (state_nxt_s == PULSE_ON) begin
      led_nxt_s = 2'b11;
    end else begin
      led_nxt_s = 2'b00;
    end
  end

endmodule

// File: tb/tb_status_blink_coder.sv
// Bench for status_blink_coder: directed scenarios plus random traffic against
// a waveform model computed from pulse/period arithmetic.
module tb_status_blink_coder;

  localparam int TD  = 4;
  localparam int ON  = 2;
  localparam int OFF = 2;
  localparam int GAP = 6;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       code_valid = 1'b0;
  logic [2:0] code = 3'd0;
  logic       clear = 1'b0;
  logic       code_ready;
  logic       busy;
  logic       led_override_en;
  logic [1:0] led_override;

  int n_checks = 0;
  int n_fail = 0;
  int act = 0;
  int t = 0;
  int pend_q[$];

  status_blink_coder #(
    .TICK_DIV(TD), .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .code_valid(code_valid),
    .code(code),
    .code_ready(code_ready),
    .clear(clear),
    .busy(busy),
    .led_override_en(led_override_en),
    .led_override(led_override)
  );

  always #5 clk = ~clk;

  function automatic int seq_period(input int n);
    return (n * (ON + OFF) - OFF + GAP) * TD;
  endfunction

  // LED is lit in the first ON*TD clocks of each of the n pulse slots
  function automatic int exp_led(input int n, input int tt);
    int slot;
    slot = (ON + OFF) * TD;
    if (n != 0 && (tt / slot) < n && (tt % slot) < ON * TD) return 3;
    return 0;
  endfunction

  task automatic check_value(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    check_value("busy", busy, (act != 0) ? 1 : 0);
    check_value("led_override_en", led_override_en, (act != 0) ? 1 : 0);
    check_value("led_override", led_override, exp_led(act, t));
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic clr);
    int rdy;
    int acc;
    int p;
    code_valid = v;
    code = c;
    clear = clr;
    #1;
    rdy = (!clr && (act == 0 || pend_q.size() == 0)) ? 1 : 0;
    check_value("code_ready", code_ready, rdy);
    @(posedge clk);
    acc = (v && rdy != 0) ? 1 : 0;
    if (clr) begin
      act = 0;
      pend_q.delete();
    end else if (act == 0) begin
      if (acc != 0 && c != 3'd0) begin
        act = int'(c);
        t = 0;
      end
    end else begin
      t++;
      if (t == seq_period(act)) begin
        t = 0;
        if (pend_q.size() > 0) begin
          p = pend_q.pop_front();
          act = p;
        end
      end
      if (acc != 0) pend_q.push_back(int'(c));
    end
    #1;
    check_outputs();
  endtask

  initial begin
    #23 nreset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
    check_value("reset_code_ready", code_ready, 1);

    for (int i = 0; i < 100; i++) step(1'b0, 3'd0, 1'b0);

    step(1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 140; i++) step(1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b1);

    step(1'b1, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd5, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 200; i++) step(1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b1);

    step(1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 1'b0);

    step(1'b1, 3'd4, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd7, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 3'd0, 1'b0);

    // Asynchronous reset in the middle of the first pulse
    step(1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0);
    code_valid = 1'b0;
    clear = 1'b0;
    #2 nreset = 1'b0;
    #1;
    act = 0;
    pend_q.delete();
    check_outputs();
    check_value("reset_code_ready", code_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #3 nreset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
    step(1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 80; i++) step(1'b0, 3'd0, 1'b0);

    for (int i = 0; i < 8000; i++) begin
      step(($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 299) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
